apresenta_sequencia: RTL and testbench

Playback engine for the memory game: on request, reads the stored sequence from the 16x4 sync ROM at addresses 0..limite and shows each entry on the 4 LEDs for a fixed on-time, followed by a blank gap. It is the output-direction counterpart of the play-capture datapath: that path compares player presses against ROM contents, while this block presents the ROM contents to the player. The block owns the ROM address while ocupado=1. The control unit starts it before each round and waits for pronto.

---
 rtl/apresenta_sequencia_pkg.sv | 20 ++
 rtl/temporizador_apresenta.sv | 35 +++
 rtl/apresenta_sequencia.sv | 122 ++++++++++++
 tb/tb_apresenta_sequencia.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/apresenta_sequencia_pkg.sv
// rtl/apresenta_sequencia_pkg.sv - shared constants for the sequence playback engine
// Purpose: state encoding (also decoded by the game control unit's debug view)
//          and the ROM / timer widths used by the playback datapath.
package apresenta_sequencia_pkg;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 4;
    localparam int TIMER_W = 16;

    typedef enum logic [3:0] {
        OCIOSO   = 4'd0,
        ENDERECA = 4'd1,
        CARREGA  = 4'd2,
        ACENDE   = 4'd3,
        APAGA    = 4'd4,
        PROXIMO  = 4'd5,
        FIM      = 4'd6
    } estado_t;

endpackage

// File: rtl/temporizador_apresenta.sv
// rtl/temporizador_apresenta.sv - 16-bit up-counter with terminal-count compare
// Purpose: times the lit and blank phases of each presented entry.
// Ports:
//   clock    - system clock, rising edge
//   reset    - asynchronous active-low reset, clears the count
//   limpa    - synchronous clear (wins over conta)
//   conta    - count enable
//   terminal - value that the count is compared against
//   fim      - high while the count equals terminal
module temporizador_apresenta
    import apresenta_sequencia_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               limpa,
    input  logic               conta,
    input  logic [TIMER_W-1:0] terminal,
    output logic               fim
);

    logic [TIMER_W-1:0] valor;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor <= '0;
        end else if (limpa) begin
            valor <= '0;
        end else if (conta) begin
            valor <= valor + TIMER_W'(1);
        end
    end

    assign fim = (valor == terminal);

endmodule

// File: rtl/apresenta_sequencia.sv
// rtl/apresenta_sequencia.sv - memory-game playback engine for the stored sequence
// Purpose: on iniciar, walks ROM addresses 0..limite and shows each entry on the
//          LEDs for ON_CYCLES clocks followed by OFF_CYCLES blank clocks.
// Ports:
//   clock        - system clock, rising edge
//   reset        - asynchronous active-low reset
//   iniciar      - start request, honoured only when idle
//   cancelar     - synchronous abort back to idle, no pronto pulse
//   limite       - last ROM address to present, latched at start
//   rom_endereco - registered ROM address (owned by this block while ocupado)
//   rom_dado     - sync ROM data, valid one clock after the address
//   leds         - registered display value, nonzero only while lit
//   ocupado      - high whenever not idle
//   pronto       - one-cycle pulse after the last entry's blank gap
//   db_estado    - current state code
module apresenta_sequencia
    import apresenta_sequencia_pkg::*;
#(
    parameter int ON_CYCLES  = 1000,
    parameter int OFF_CYCLES = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              cancelar,
    input  logic [ADDR_W-1:0] limite,
    output logic [ADDR_W-1:0] rom_endereco,
    input  logic [DATA_W-1:0] rom_dado,
    output logic [DATA_W-1:0] leds,
    output logic              ocupado,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    localparam logic [TIMER_W-1:0] ON_TERM  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_TERM = TIMER_W'(OFF_CYCLES - 1);

    estado_t              estadoAtual;
    estado_t              proximoEstado;
    logic [ADDR_W-1:0]    endereco;
    logic [ADDR_W-1:0]    limiteReg;
    logic [DATA_W-1:0]    ledsReg;
    logic                 timerFim;
    logic                 timerLimpa;
    logic                 timerConta;
    logic [TIMER_W-1:0]   timerTerminal;

    temporizador_apresenta uTemporizador (
        .clock    (clock),
        .reset    (reset),
        .limpa    (timerLimpa),
        .conta    (timerConta),
        .terminal (timerTerminal),
        .fim      (timerFim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estadoAtual <= OCIOSO;
        end else begin
            estadoAtual <= proximoEstado;
        end
    end

    always_comb begin
        proximoEstado = estadoAtual;
        if (cancelar) begin
            proximoEstado = OCIOSO;
        end else begin
            case (estadoAtual)
                OCIOSO:   if (iniciar) proximoEstado = ENDERECA;
                ENDERECA: proximoEstado = CARREGA;
                CARREGA:  proximoEstado = ACENDE;
                ACENDE:   if (timerFim) proximoEstado = APAGA;
                APAGA:    if (timerFim) proximoEstado = PROXIMO;
                PROXIMO:  proximoEstado = (endereco == limiteReg) ? FIM : ENDERECA;
                FIM:      proximoEstado = OCIOSO;
                default:  proximoEstado = OCIOSO;
            endcase
        end
    end

    // The timer only runs in the two timed phases; everywhere else it is held
    // at zero so each phase starts from a clean count.
    always_comb begin
        ocupado       = (estadoAtual != OCIOSO);
        pronto        = (estadoAtual == FIM);
        db_estado     = estadoAtual;
        timerConta    = (estadoAtual == ACENDE) || (estadoAtual == APAGA);
        timerTerminal = (estadoAtual == APAGA) ? OFF_TERM : ON_TERM;
        timerLimpa    = cancelar || !timerConta || timerFim;
    end

    // Address, latched limit and LED value; the address is deliberately left
    // untouched by cancelar so the control unit can see where playback stopped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco  <= '0;
            limiteReg <= '0;
            ledsReg   <= '0;
        end else if (cancelar) begin
            ledsReg <= '0;
        end else begin
            case (estadoAtual)
                OCIOSO: begin
                    if (iniciar) begin
                        endereco  <= '0;
                        limiteReg <= limite;
                    end
                end
                CARREGA: ledsReg <= rom_dado;
                ACENDE:  if (timerFim) ledsReg <= '0;
                PROXIMO: if (endereco != limiteReg) endereco <= endereco + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    assign rom_endereco = endereco;
    assign leds         = ledsReg;

endmodule

// File: tb/tb_apresenta_sequencia.sv
// tb/tb_apresenta_sequencia.sv - self-checking bench for apresenta_sequencia
module tb_apresenta_sequencia;

    localparam int TB_ON  = 4;
    localparam int TB_OFF = 2;
    localparam int SLOT   = TB_ON + TB_OFF + 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       cancelar;
    logic [3:0] limite;
    logic [3:0] rom_endereco;
    logic [3:0] rom_dado;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] rom [16];

    int total = 0;
    int bad   = 0;
    bit checkOn = 1'b0;

    int prontoCyc;
    int prontoCnt;
    logic [3:0] litSeen [16];

    bit         mActive;
    int         mN;
    logic [3:0] mL;
    logic [3:0] mIdleAddr;

    apresenta_sequencia #(.ON_CYCLES(TB_ON), .OFF_CYCLES(TB_OFF)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .cancelar     (cancelar),
        .limite       (limite),
        .rom_endereco (rom_endereco),
        .rom_dado     (rom_dado),
        .leds         (leds),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_dado <= rom[rom_endereco];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int runLen(input logic [3:0] l);
        return (int'(l) + 1) * SLOT + 1;
    endfunction

    function automatic logic [3:0] modelAddr(input int n, input logic [3:0] l);
        if (n >= runLen(l)) return l;
        return 4'((n - 1) / SLOT);
    endfunction

    // Model: cycle n of a run (n=1 is the cycle after the accepting edge).
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mActive   <= 1'b0;
            mN        <= 0;
            mL        <= '0;
            mIdleAddr <= '0;
        end else if (cancelar) begin
            if (mActive) begin
                mActive   <= 1'b0;
                mIdleAddr <= modelAddr(mN, mL);
            end
        end else if (mActive) begin
            if (mN == runLen(mL)) begin
                mActive   <= 1'b0;
                mIdleAddr <= mL;
            end else begin
                mN <= mN + 1;
            end
        end else if (iniciar) begin
            mActive <= 1'b1;
            mN      <= 1;
            mL      <= limite;
        end
    end

    always @(negedge clock) begin : compare
        int eL, eA, eD, eO, eP, k, off;
        if (checkOn) begin
            if (!mActive) begin
                eL = 0; eA = mIdleAddr; eD = 0; eO = 0; eP = 0;
            end else if (mN == runLen(mL)) begin
                eL = 0; eA = mL; eD = 6; eO = 1; eP = 1;
            end else begin
                k   = (mN - 1) / SLOT;
                off = (mN - 1) % SLOT;
                eA  = k; eO = 1; eP = 0;
                eL  = (off >= 2 && off < 2 + TB_ON) ? int'(rom[k]) : 0;
                if (off == 0)                    eD = 1;
                else if (off == 1)               eD = 2;
                else if (off < 2 + TB_ON)        eD = 3;
                else if (off < 2 + TB_ON + TB_OFF) eD = 4;
                else                             eD = 5;
            end
            chk("cyc_leds", int'(leds), eL);
            chk("cyc_rom_endereco", int'(rom_endereco), eA);
            chk("cyc_db_estado", int'(db_estado), eD);
            chk("cyc_ocupado", int'(ocupado), eO);
            chk("cyc_pronto", int'(pronto), eP);
        end
    end

    task automatic runSeq(input logic [3:0] lim, input int budget, input int injCyc,
                          input logic [3:0] injLim, input int canCyc);
        @(negedge clock); #1;
        limite  = lim;
        iniciar = 1'b1;
        @(negedge clock); #1;
        iniciar   = 1'b0;
        prontoCyc = 0;
        prontoCnt = 0;
        for (int i = 0; i < 16; i++) litSeen[i] = 4'hF;
        for (int c = 1; c <= budget; c++) begin
            if (pronto) begin
                prontoCnt++;
                if (prontoCyc == 0) prontoCyc = c;
            end
            if (c >= 3 && ((c - 3) % SLOT) == 0 && ((c - 3) / SLOT) < 16)
                litSeen[(c - 3) / SLOT] = leds;
            if (c == injCyc) begin
                iniciar = 1'b1;
                limite  = injLim;
            end else begin
                iniciar = 1'b0;
            end
            cancelar = (c == canCyc);
            @(negedge clock); #1;
        end
        iniciar  = 1'b0;
        cancelar = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        iniciar  = 1'b0;
        cancelar = 1'b0;
        limite   = 4'd0;
        for (int i = 0; i < 16; i++) rom[i] = 4'(1 << (i % 4));
        checkOn = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        chk("reset_leds", int'(leds), 0);
        chk("reset_addr", int'(rom_endereco), 0);
        chk("reset_db", int'(db_estado), 0);
        chk("reset_ocupado", int'(ocupado), 0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk("idle_db", int'(db_estado), 0);

        // single entry
        runSeq(4'd0, 15, 0, 4'd0, 0);
        chk("t2_pronto_cyc", prontoCyc, 10);
        chk("t2_pronto_cnt", prontoCnt, 1);
        chk("t2_lit0", int'(litSeen[0]), 1);

        // three entries
        runSeq(4'd2, 35, 0, 4'd0, 0);
        chk("t3_pronto_cyc", prontoCyc, 28);
        chk("t3_lit0", int'(litSeen[0]), 1);
        chk("t3_lit1", int'(litSeen[1]), 2);
        chk("t3_lit2", int'(litSeen[2]), 4);
        chk("t3_addr_end", int'(rom_endereco), 2);

        // full ROM
        runSeq(4'd15, 150, 0, 4'd0, 0);
        chk("t4_pronto_cyc", prontoCyc, 145);
        chk("t4_lit15", int'(litSeen[15]), 8);
        chk("t4_addr_end", int'(rom_endereco), 15);

        // iniciar and limite change during a run are ignored
        runSeq(4'd0, 15, 5, 4'd3, 0);
        chk("t5_pronto_cyc", prontoCyc, 10);
        chk("t5_pronto_cnt", prontoCnt, 1);

        // cancel in APAGA of entry 1 (cycle 16)
        runSeq(4'd1, 25, 0, 4'd0, 16);
        chk("t5c_pronto_cnt", prontoCnt, 0);
        chk("t5c_db", int'(db_estado), 0);
        chk("t5c_leds", int'(leds), 0);
        chk("t5c_addr_hold", int'(rom_endereco), 1);

        // zero entry still gets its full slot
        rom[1] = 4'd0;
        runSeq(4'd1, 25, 0, 4'd0, 0);
        chk("t6_pronto_cyc", prontoCyc, 19);
        chk("t6_lit0", int'(litSeen[0]), 1);
        chk("t6_lit1", int'(litSeen[1]), 0);
        rom[1] = 4'd2;

        // asynchronous reset in the middle of ACENDE of entry 1
        runSeq(4'd2, 12, 0, 4'd0, 0);
        chk("t1_pre_leds", int'(leds), 2);
        #2;
        reset = 1'b0;
        #1;
        chk("t1_async_leds", int'(leds), 0);
        chk("t1_async_addr", int'(rom_endereco), 0);
        chk("t1_async_db", int'(db_estado), 0);
        @(negedge clock); #1;
        reset = 1'b1;
        repeat (5) @(negedge clock);
        #1;
        chk("t1_idle_db", int'(db_estado), 0);
        chk("t1_idle_ocupado", int'(ocupado), 0);
        runSeq(4'd0, 15, 0, 4'd0, 0);
        chk("t1_rerun_pronto", prontoCyc, 10);

        checkOn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
